// File: rtl/seg7_scan_mux.sv
// Scanned 4-digit common-anode 7-segment driver with per-frame input shadowing.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.

module seg7_digit (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // active-low {g,f,e,d,c,b,a}
  always_comb begin
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

module seg7_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] dp_en,
  input  logic [3:0] dig_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);
  localparam int NUM_DIG = 4;
  localparam int DIV_W   = $clog2(REFRESH_DIV);

  logic [DIV_W-1:0]            div;
  logic [1:0]                  idx;
  logic                        load_pend;
  logic [NUM_DIG-1:0][3:0]     sh_in;
  logic [NUM_DIG-1:0]          sh_dp, sh_en;
  logic [NUM_DIG-1:0][6:0]     dig_seg;
  logic [NUM_DIG-1:0]          sup;
  logic                        div_wrap, load, blank;

  assign div_wrap = (div == DIV_W'(REFRESH_DIV - 1));
  // frame boundary is the last cycle of digit 3's slot; load_pend forces a load right after reset
  assign load     = load_pend || (div_wrap && idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      idx       <= '0;
      load_pend <= 1'b1;
      sh_in     <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
    end else begin
      div <= div_wrap ? '0 : div + DIV_W'(1);
      if (div_wrap) idx <= idx + 2'd1;
      if (load) begin
        load_pend <= 1'b0;
        sh_in     <= {in3, in2, in1, in0};
        sh_dp     <= dp_en;
        sh_en     <= dig_en;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    seg7_digit u_dig (.nib(sh_in[g]), .seg(dig_seg[g]));
  end

`ifdef SEG7_LZB_EN
  // a digit is dark only if it and every digit above it is a zero with no dp
  always_comb begin
    sup    = '0;
    sup[3] = (sh_in[3] == 4'h0) && !sh_dp[3];
    for (int k = 2; k >= 1; k--)
      sup[k] = sup[k+1] && (sh_in[k] == 4'h0) && !sh_dp[k];
  end
`else
  assign sup = '0;
`endif

  assign blank = (div < DIV_W'(BLANK_CYC)) || !sh_en[idx] || sup[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= blank ? 4'hF  : ~(4'b0001 << idx);
      seg        <= blank ? 7'h7F : dig_seg[idx];
      dp         <= blank ? 1'b1  : ~sh_dp[idx];
      frame_tick <= load;
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux at REFRESH_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_mux;
  localparam int RD = 8;
  localparam int BC = 2;
`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [3:0] dp_en = '0, dig_en = '0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] fin [2][4];   // expected shadow nibbles: first frame, later frames
  logic [3:0] e_dp, e_en;

  seg7_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .dp_en(dp_en), .dig_en(dig_en), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] a3, a2, a1, a0, input logic [3:0] dpe, den);
    in3 = a3; in2 = a2; in1 = a1; in0 = a0; dp_en = dpe; dig_en = den;
    fin[0][3] = a3; fin[0][2] = a2; fin[0][1] = a1; fin[0][0] = a0;
    fin[1] = fin[0];
    e_dp = dpe; e_en = den;
  endtask

  function automatic bit tsup(int fr, int d);
    if (!LZB || d == 0) return 1'b0;
    for (int j = d; j < 4; j++)
      if (fin[fr][j] != 4'h0 || e_dp[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic reset_chk(input string nm);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk({nm, ".rst.an"}, 16'(an), 16'hF);
    chk({nm, ".rst.seg"}, 16'(seg), 16'h7F);
    chk({nm, ".rst.dp"}, 16'(dp), 16'h1);
    chk({nm, ".rst.ft"}, 16'(frame_tick), 16'h0);
    rst_n = 1'b1;
  endtask

  // k counts edges since reset release; checks outputs after each edge
  task automatic scan(input string nm, input int n, input int chg_k, input logic [3:0] chg_v);
    int slot, d, fr;
    logic [3:0] xa;
    logic [6:0] xs;
    logic       xd, xf;
    if (chg_k > 0) fin[1][0] = chg_v;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      slot = (k - 1) % RD;
      d    = ((k - 1) / RD) % 4;
      fr   = (k <= 4 * RD) ? 0 : 1;
      xa = 4'hF; xs = 7'h7F; xd = 1'b1;
      if (slot >= BC && e_en[d] && !tsup(fr, d)) begin
        xa = ~(4'b0001 << d);
        xs = HEX[fin[fr][d]];
        xd = ~e_dp[d];
      end
      xf = (k == 1) || (k % (4 * RD) == 0);
      chk($sformatf("%s.k%0d.an", nm, k), 16'(an), 16'(xa));
      chk($sformatf("%s.k%0d.seg", nm, k), 16'(seg), 16'(xs));
      chk($sformatf("%s.k%0d.dp", nm, k), 16'(dp), 16'(xd));
      chk($sformatf("%s.k%0d.ft", nm, k), 16'(frame_tick), 16'(xf));
      if (k == chg_k) in0 = chg_v;
    end
  endtask

  initial begin
    // basic scan; in0 changes 1->8 during digit 2's slot, visible from next frame only
    set_in(4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF);
    reset_chk("scan");
    scan("scan", 72, 20, 4'h8);

    // partial digit enable and decimal point
    set_in(4'h4, 4'h3, 4'h2, 4'h1, 4'b0001, 4'b0101);
    reset_chk("en");
    scan("en", 34, 0, 4'h0);

    // leading zeros
    set_in(4'h0, 4'h0, 4'h0, 4'h5, 4'h0, 4'hF);
    reset_chk("lz");
    scan("lz", 34, 0, 4'h0);

    // async reset in digit 2's slot, no clock edge needed
    set_in(4'hA, 4'hB, 4'hC, 4'hD, 4'b1000, 4'hF);
    reset_chk("ar");
    scan("ar", 20, 0, 4'h0);
    chk("ar.pre.an", 16'(an), 16'hB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.async.an", 16'(an), 16'hF);
    chk("ar.async.seg", 16'(seg), 16'h7F);
    chk("ar.async.dp", 16'(dp), 16'h1);
    chk("ar.async.ft", 16'(frame_tick), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    scan("resume", 12, 0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
